// File: rtl/mult_issue_ctrl_if.sv
// ID-stage to multiply-issue-controller handshake: instruction fields and ready/flush.
interface mult_issue_ctrl_if;
    logic       id_valid;
    logic       id_ready;
    logic       flush;
    logic       id_is_mult;
    logic [1:0] id_mult_type;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd_addr;

    modport master (
        output id_valid, flush, id_is_mult, id_mult_type,
               id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_rd_addr,
        input  id_ready
    );

    modport slave (
        input  id_valid, flush, id_is_mult, id_mult_type,
               id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_rd_addr,
        output id_ready
    );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Multiply issue/hazard controller: per-stage destination scoreboard, RAW/WAW/
// write-port stalls, multiplier launch, write-back request and bypass selects.
module mult_issue_ctrl #(
    parameter int STAGES  = 3,
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    mult_issue_ctrl_if.slave    id,
    output logic                mult_use_o,
    output logic [1:0]          mult_type_o,
    output logic                fwd_rs1,
    output logic                fwd_rs2,
    output logic                wb_mult_valid,
    output logic [4:0]          wb_mult_rd,
    output logic [1:0]          wb_mult_type,
    output logic [3:0]          inflight,
    output logic                busy
);
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [1:0] mtype;
    } entry_t;

    // Entry whose retirement coincides with the write of an ALU op accepted now.
    localparam int PORT_IDX = STAGES - 1 - ALU_LAT;

    entry_t sb [STAGES];
    entry_t load;
    logic   raw, waw, port, stall, accept;

    function automatic logic hit(entry_t e, logic [4:0] addr);
        return e.v && (addr != 5'd0) && (e.rd == addr);
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        for (int j = 0; j < STAGES - 1; j++) begin
            if ((id.id_rs1_used && hit(sb[j], id.id_rs1_addr)) ||
                (id.id_rs2_used && hit(sb[j], id.id_rs2_addr)))
                raw = 1'b1;
            if (hit(sb[j], id.id_rd_addr))
                waw = 1'b1;
        end
    end

    assign port   = !id.id_is_mult && (id.id_rd_addr != 5'd0) &&
                    sb[PORT_IDX].v && (sb[PORT_IDX].rd != 5'd0);
    assign stall  = id.id_valid && (raw || waw || port);
    assign accept = id.id_valid && !id.flush && !stall;

    assign id.id_ready  = !stall && !id.flush;
    assign mult_use_o   = accept && id.id_is_mult;
    assign mult_type_o  = id.id_mult_type;

    assign fwd_rs1 = id.id_rs1_used && hit(sb[STAGES-1], id.id_rs1_addr);
    assign fwd_rs2 = id.id_rs2_used && hit(sb[STAGES-1], id.id_rs2_addr);

    assign wb_mult_valid = sb[STAGES-1].v && (sb[STAGES-1].rd != 5'd0);
    assign wb_mult_rd    = sb[STAGES-1].rd;
    assign wb_mult_type  = sb[STAGES-1].mtype;

    always_comb begin
        inflight = 4'd0;
        for (int j = 0; j < STAGES; j++)
            inflight = inflight + {3'd0, sb[j].v};
    end
    assign busy = (inflight != 4'd0);

    always_comb begin
        load = '0;
        if (mult_use_o)
            load = '{v: 1'b1, rd: id.id_rd_addr, mtype: id.id_mult_type};
    end

    // NOTE: sequential state uses non-blocking assignments so the shift reads pre-edge values.
    // NOTE: every scoreboard entry is reset, since a stale v bit would fire a write-back after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < STAGES; j++)
                sb[j] <= '0;
        end else begin
            sb[0] <= load;
            for (int j = 1; j < STAGES; j++)
                sb[j] <= sb[j-1];
        end
    end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed cycle-by-cycle bench for mult_issue_ctrl with STAGES=3, ALU_LAT=1.
module tb_mult_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       mult_use_o, fwd_rs1, fwd_rs2, wb_mult_valid, busy;
    logic [1:0] mult_type_o, wb_mult_type;
    logic [4:0] wb_mult_rd;
    logic [3:0] inflight;

    int total = 0;
    int bad   = 0;

    mult_issue_ctrl_if bus ();

    mult_issue_ctrl #(.STAGES(3), .ALU_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .id            (bus.slave),
        .mult_use_o    (mult_use_o),
        .mult_type_o   (mult_type_o),
        .fwd_rs1       (fwd_rs1),
        .fwd_rs2       (fwd_rs2),
        .wb_mult_valid (wb_mult_valid),
        .wb_mult_rd    (wb_mult_rd),
        .wb_mult_type  (wb_mult_type),
        .inflight      (inflight),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid, flush, is_mult;
        logic [1:0] mtype;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       ready, use_m, f1, f2, wbv;
        logic [4:0] wbrd;
        logic [1:0] wbt;
        logic [3:0] infl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic valid, flush, is_mult, input logic [1:0] mtype,
        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
        input logic [4:0] rd,
        input logic ready, use_m, f1, f2, wbv, input logic [4:0] wbrd,
        input logic [1:0] wbt, input logic [3:0] infl);
        vec_t t;
        t.valid = valid; t.flush = flush; t.is_mult = is_mult; t.mtype = mtype;
        t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
        t.ready = ready; t.use_m = use_m; t.f1 = f1; t.f2 = f2; t.wbv = wbv;
        t.wbrd = wbrd; t.wbt = wbt; t.infl = infl;
        return t;
    endfunction

    function automatic vec_t idle(input logic wbv, input logic [4:0] wbrd,
                                  input logic [1:0] wbt, input logic [3:0] infl);
        return mk(0,0,0,0, 0,0,0,0, 0, 1,0,0,0, wbv,wbrd,wbt,infl);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.id_valid     = t.valid;
        bus.flush        = t.flush;
        bus.id_is_mult   = t.is_mult;
        bus.id_mult_type = t.mtype;
        bus.id_rs1_addr  = t.rs1;
        bus.id_rs1_used  = t.u1;
        bus.id_rs2_addr  = t.rs2;
        bus.id_rs2_used  = t.u2;
        bus.id_rd_addr   = t.rd;
    endtask

    task automatic check_all(input string tag, input vec_t t);
        check({tag, " id_ready"},      32'(bus.id_ready),  32'(t.ready));
        check({tag, " mult_use_o"},    32'(mult_use_o),    32'(t.use_m));
        check({tag, " mult_type_o"},   32'(mult_type_o),   32'(t.mtype));
        check({tag, " fwd_rs1"},       32'(fwd_rs1),       32'(t.f1));
        check({tag, " fwd_rs2"},       32'(fwd_rs2),       32'(t.f2));
        check({tag, " wb_mult_valid"}, 32'(wb_mult_valid), 32'(t.wbv));
        check({tag, " wb_mult_rd"},    32'(wb_mult_rd),    32'(t.wbrd));
        check({tag, " wb_mult_type"},  32'(wb_mult_type),  32'(t.wbt));
        check({tag, " inflight"},      32'(inflight),      32'(t.infl));
        check({tag, " busy"},          32'(busy),          32'(t.infl != 4'd0));
    endtask

    initial begin
        // Back-to-back launches covering all four types, then drain.
        tbl.push_back(mk(1,0,1,0, 0,0,0,0, 5,  1,1,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,1,1, 0,0,0,0, 6,  1,1,0,0, 0,0,0,1));
        tbl.push_back(mk(1,0,1,2, 0,0,0,0, 7,  1,1,0,0, 0,0,0,2));
        tbl.push_back(mk(1,0,1,3, 0,0,0,0, 8,  1,1,0,0, 1,5,0,3));
        tbl.push_back(idle(1,6,1,3));
        tbl.push_back(idle(1,7,2,2));
        tbl.push_back(idle(1,8,3,1));
        // RAW on rs1: held two cycles, accepted with forwarding.
        tbl.push_back(mk(1,0,1,0, 0,0,0,0, 5,  1,1,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 5,1,0,0, 10, 0,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0, 5,1,0,0, 10, 0,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0, 5,1,0,0, 10, 1,0,1,0, 1,5,0,1));
        tbl.push_back(idle(0,0,0,0));
        // rd=0 multiply: counted, never written, never matched.
        tbl.push_back(mk(1,0,1,1, 0,0,0,0, 0,  1,1,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,1,0,1, 12, 1,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0, 13, 1,0,0,0, 0,0,0,1));
        tbl.push_back(idle(0,0,1,1));
        tbl.push_back(idle(0,0,0,0));
        // Write-port collision.
        tbl.push_back(mk(1,0,1,2, 0,0,0,0, 7,  1,1,0,0, 0,0,0,0));
        tbl.push_back(idle(0,0,0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0, 9,  0,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0, 9,  1,0,0,0, 1,7,2,1));
        tbl.push_back(idle(0,0,0,0));
        // WAW.
        tbl.push_back(mk(1,0,1,3, 0,0,0,0, 4,  1,1,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0, 4,  0,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0, 4,  0,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0, 4,  1,0,0,0, 1,4,3,1));
        tbl.push_back(idle(0,0,0,0));
        // RAW on rs2 for a dependent multiply; launch coincides with retire.
        tbl.push_back(mk(1,0,1,0, 0,0,0,0, 9,  1,1,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,1,0, 0,0,9,1, 15, 0,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,0,1,0, 0,0,9,1, 15, 0,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,0,1,0, 0,0,9,1, 15, 1,1,0,1, 1,9,0,1));
        tbl.push_back(idle(0,0,0,1));
        tbl.push_back(idle(0,0,0,1));
        tbl.push_back(idle(1,15,0,1));
        tbl.push_back(idle(0,0,0,0));
        // Flush alone, then flush together with a RAW stall.
        tbl.push_back(mk(1,1,1,0, 0,0,0,0, 3,  0,0,0,0, 0,0,0,0));
        tbl.push_back(idle(0,0,0,0));
        tbl.push_back(mk(1,0,1,0, 0,0,0,0, 5,  1,1,0,0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,0, 5,1,0,0, 10, 0,0,0,0, 0,0,0,1));
        tbl.push_back(idle(0,0,0,1));
        tbl.push_back(idle(1,5,0,1));
        tbl.push_back(idle(0,0,0,0));

        drive(idle(0,0,0,0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all("reset", idle(0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1 drive(tbl[i]);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i]);
        end

        // Mid-flight reset: launch, reset next cycle, no write-back afterwards.
        @(posedge clk);
        #1 drive(mk(1,0,1,2, 0,0,0,0, 5, 1,1,0,0, 0,0,0,0));
        @(negedge clk);
        check("rst_seq launch", 32'(mult_use_o), 32'd1);
        @(posedge clk);
        #1 drive(idle(0,0,0,0));
        rst = 1'b1;
        @(negedge clk);
        check("rst_seq inflight before edge", 32'(inflight), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_seq inflight c2", 32'(inflight), 32'd0);
        check("rst_seq wb c2", 32'(wb_mult_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_seq wb c3", 32'(wb_mult_valid), 32'd0);
        check("rst_seq inflight c3", 32'(inflight), 32'd0);
        check("rst_seq busy c3", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
